// File: rtl/token_expander.sv
// token_expander: sits between imem fetch and the decoder. Raw instruction
// words pass straight through; a token word (top nibble == MARKER) is expanded
// into a run of 1..16 instructions read from the token table's synchronous
// read port. One instruction at a time is handed to the decoder over
// valid/ready.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   flush             synchronous flush, drops any pending word or expansion
//   in_valid/in_ready/in_data       upstream word stream (in_ready is combinational)
//   out_valid/out_ready/out_data    instruction stream to the decoder
//   out_expanded      out_data came from the token table
//   tbl_en/tbl_addr/tbl_data        token table read port (data one cycle after tbl_en)
//   busy              expansion in progress (FETCH, LOAD or EMIT)
module token_expander #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 8,
  parameter logic [3:0]  MARKER = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_expanded,
  output logic              tbl_en,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [WIDTH-1:0]  tbl_data,
  output logic              busy
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned LEN_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_FETCH,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  base, base_nx;
  logic [LEN_W-1:0]   len, len_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [WIDTH-1:0]   out_data_nx;
  logic               out_exp_nx;
  logic [ADDR_W-1:0]  tbl_addr_nx;
  logic               in_xfer;
  logic               is_token;
  logic               last_word;

  // Accept only when idle; flush and reset both block the transfer.
  assign in_ready  = (state == S_IDLE) && reset && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign is_token  = (in_data[WIDTH-1 -: 4] == MARKER);
  assign last_word = (LEN_W'(idx) == (len - LEN_W'(1)));

  // Next-state and datapath next values.
  always_comb begin
    state_nx    = state;
    base_nx     = base;
    len_nx      = len;
    idx_nx      = idx;
    out_data_nx = out_data;
    out_exp_nx  = out_expanded;

    case (state)
      S_IDLE: begin
        if (in_xfer) begin
          if (is_token) begin
            base_nx  = in_data[ADDR_W-1:0];
            len_nx   = LEN_W'(in_data[WIDTH-5 -: 4]) + LEN_W'(1);
            idx_nx   = '0;
            state_nx = S_FETCH;
          end else begin
            out_data_nx = in_data;
            out_exp_nx  = 1'b0;
            state_nx    = S_PASS;
          end
        end
      end
      S_PASS: begin
        if (out_ready) state_nx = S_IDLE;
      end
      S_FETCH: begin
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        out_data_nx = tbl_data;
        out_exp_nx  = 1'b1;
        state_nx    = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_word) begin
            state_nx = S_IDLE;
          end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = S_FETCH;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Flush overrides everything; a coincident handshake is simply not followed up.
    if (flush) state_nx = S_IDLE;
  end

  // Table address wraps naturally at 2^ADDR_W.
  assign tbl_addr_nx = base_nx + ADDR_W'(idx_nx);

  // State, datapath and registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      base         <= '0;
      len          <= '0;
      idx          <= '0;
      out_data     <= '0;
      out_expanded <= 1'b0;
      out_valid    <= 1'b0;
      tbl_en       <= 1'b0;
      tbl_addr     <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      base         <= base_nx;
      len          <= len_nx;
      idx          <= idx_nx;
      out_data     <= out_data_nx;
      out_expanded <= out_exp_nx;
      out_valid    <= (state_nx == S_PASS) || (state_nx == S_EMIT);
      tbl_en       <= (state_nx == S_FETCH);
      tbl_addr     <= tbl_addr_nx;
      busy         <= (state_nx == S_FETCH) || (state_nx == S_LOAD) ||
                      (state_nx == S_EMIT);
    end
  end

endmodule
